// File: rtl/mphase_gen.sv
// rtl/mphase_gen.sv - multi-phase interleaved clock-enable generator with phase rotation
module mphase_gen #(
  parameter int NPH = 8,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] div_cfg,
  input  logic          rot_req,
  input  logic          rot_dir,
  output logic          rot_ack,
  output logic [NPH-1:0] fmp,
  output logic          wrap
);

  localparam int SW = $clog2(NPH);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  tcnt, tcnt_nx;
  logic [CW-1:0]  div_q, div_q_nx, div_ld;
  logic [SW-1:0]  sidx, sidx_nx;
  logic [NPH-1:0] fmp_nx;
  logic           rot_ack_nx, wrap_nx, take_rot;
  logic [1:0]     inc;
  logic [SW:0]    sum;
  logic [SW-1:0]  d;

  always_comb begin
    state_nx   = state;
    tcnt_nx    = tcnt;
    sidx_nx    = sidx;
    div_q_nx   = div_q;
    fmp_nx     = fmp;
    rot_ack_nx = 1'b0;
    wrap_nx    = 1'b0;
    take_rot   = 1'b0;
    inc        = 2'd1;
    sum        = '0;
    d          = '0;
    div_ld     = (div_cfg == '0) ? ONE : div_cfg;
    case (state)
      IDLE: begin
        fmp_nx = '0;
        if (en) begin
          state_nx = RUN;
          div_q_nx = div_ld;
          tcnt_nx  = '0;
        end
      end
      RUN: begin
        if (en) begin
          if (tcnt == div_q - ONE) begin
            tcnt_nx  = '0;
            // A request still high while its ack is showing is the same request.
            take_rot = rot_req && !rot_ack;
            if (take_rot) inc = rot_dir ? 2'd2 : 2'd0;
            sum        = {1'b0, sidx} + {{(SW-1){1'b0}}, inc};
            sidx_nx    = sum[SW-1:0];
            wrap_nx    = sum[SW];
            rot_ack_nx = take_rot;
            if (sum[SW]) div_q_nx = div_ld;
            // Bit k is high for the half-cycle window where (sidx - k) mod NPH < NPH/2.
            for (int k = 0; k < NPH; k++) begin
              d         = sidx_nx - SW'(k);
              fmp_nx[k] = ~d[SW-1];
            end
          end else begin
            tcnt_nx = tcnt + ONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      sidx    <= SW'(NPH - 1);
      div_q   <= ONE;
      fmp     <= '0;
      rot_ack <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nx;
      tcnt    <= tcnt_nx;
      sidx    <= sidx_nx;
      div_q   <= div_q_nx;
      fmp     <= fmp_nx;
      rot_ack <= rot_ack_nx;
      wrap    <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_mphase_gen.sv
// tb/tb_mphase_gen.sv - directed self-checking bench for mphase_gen (NPH=8, CW=8)
module tb_mphase_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div_cfg = 8'd0;
  logic       rot_req = 1'b0;
  logic       rot_dir = 1'b0;
  logic       rot_ack;
  logic [7:0] fmp;
  logic       wrap;

  int total = 0;
  int bad = 0;

  mphase_gen #(.NPH(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .div_cfg(div_cfg),
    .rot_req(rot_req), .rot_dir(rot_dir),
    .rot_ack(rot_ack), .fmp(fmp), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // fmp pattern for each step index, worked out by hand for NPH=8
  function automatic logic [7:0] pat(input int s);
    case (s)
      0: pat = 8'hE1;
      1: pat = 8'hC3;
      2: pat = 8'h87;
      3: pat = 8'h0F;
      4: pat = 8'h1E;
      5: pat = 8'h3C;
      6: pat = 8'h78;
      default: pat = 8'hF0;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Reset, then enable with the given divide; returns just after edge E0.
  task automatic start(input logic [7:0] cfg);
    rst = 1'b1; en = 1'b0; rot_req = 1'b0; rot_dir = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; div_cfg = cfg;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rot_req = 1'b1; div_cfg = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (fmp !== 8'h00 || rot_ack !== 1'b0 || wrap !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc=%0d got fmp=%h ack=%b wrap=%b exp fmp=00 ack=0 wrap=0", i, fmp, rot_ack, wrap);
      end
    end
    rot_req = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] ef;
    logic       ew;
    start(8'd2);
    total++;
    if (fmp !== 8'h00) begin
      bad++;
      $display("FAIL basic_e0 got=%h exp=00", fmp);
    end
    for (int n = 1; n <= 34; n++) begin
      tick();
      ef = (n == 1) ? 8'h00 : pat(((n / 2) - 1) % 8);
      ew = ((n % 2) == 0) && ((((n / 2) - 1) % 8) == 0);
      total++;
      if (fmp !== ef || wrap !== ew || rot_ack !== 1'b0) begin
        bad++;
        $display("FAIL basic n=%0d got fmp=%h wrap=%b ack=%b exp fmp=%h wrap=%b ack=0", n, fmp, wrap, rot_ack, ef, ew);
      end
    end
  endtask

  task automatic test_div_change();
    logic [7:0] ef;
    logic       ew;
    int         s;
    start(8'd2);
    for (int n = 1; n <= 8; n++) tick();
    total++;
    if (fmp !== 8'h0F) begin
      bad++;
      $display("FAIL divchg_s3 got=%h exp=0F", fmp);
    end
    div_cfg = 8'd3;
    for (int n = 9; n <= 45; n++) begin
      tick();
      if (n <= 18) begin
        s  = ((n / 2) - 1) % 8;
        ew = (n == 18);
      end else begin
        s  = ((n - 18) / 3) % 8;
        ew = (n == 42);
      end
      ef = pat(s);
      total++;
      if (fmp !== ef || wrap !== ew) begin
        bad++;
        $display("FAIL divchg n=%0d got fmp=%h wrap=%b exp fmp=%h wrap=%b", n, fmp, wrap, ef, ew);
      end
    end
  endtask

  task automatic test_rot_advance();
    start(8'd2);
    for (int n = 1; n <= 6; n++) tick();
    rot_req = 1'b1; rot_dir = 1'b1;
    tick();
    total++;
    if (fmp !== 8'h87 || rot_ack !== 1'b0) begin
      bad++;
      $display("FAIL adv_e7 got fmp=%h ack=%b exp fmp=87 ack=0", fmp, rot_ack);
    end
    tick();
    total++;
    if (fmp !== 8'h1E || rot_ack !== 1'b1 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL adv_e8 got fmp=%h ack=%b wrap=%b exp fmp=1E ack=1 wrap=0", fmp, rot_ack, wrap);
    end
    rot_req = 1'b0;
    tick();
    total++;
    if (fmp !== 8'h1E || rot_ack !== 1'b0) begin
      bad++;
      $display("FAIL adv_e9 got fmp=%h ack=%b exp fmp=1E ack=0", fmp, rot_ack);
    end
    tick();
    total++;
    if (fmp !== 8'h3C) begin
      bad++;
      $display("FAIL adv_e10 got=%h exp=3C", fmp);
    end
  endtask

  task automatic test_rot_retard();
    start(8'd2);
    for (int n = 1; n <= 16; n++) tick();
    rot_req = 1'b1; rot_dir = 1'b0;
    tick();
    tick();
    total++;
    if (fmp !== 8'hF0 || wrap !== 1'b0 || rot_ack !== 1'b1) begin
      bad++;
      $display("FAIL ret_e18 got fmp=%h wrap=%b ack=%b exp fmp=F0 wrap=0 ack=1", fmp, wrap, rot_ack);
    end
    rot_req = 1'b0;
    tick();
    total++;
    if (fmp !== 8'hF0 || rot_ack !== 1'b0) begin
      bad++;
      $display("FAIL ret_e19 got fmp=%h ack=%b exp fmp=F0 ack=0", fmp, rot_ack);
    end
    tick();
    total++;
    if (fmp !== 8'hE1 || wrap !== 1'b1 || rot_ack !== 1'b0) begin
      bad++;
      $display("FAIL ret_e20 got fmp=%h wrap=%b ack=%b exp fmp=E1 wrap=1 ack=0", fmp, wrap, rot_ack);
    end
  endtask

  task automatic test_back_to_back();
    start(8'd1);
    for (int n = 1; n <= 3; n++) tick();
    rot_req = 1'b1; rot_dir = 1'b1;
    tick();
    total++;
    if (fmp !== 8'h1E || rot_ack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_e4 got fmp=%h ack=%b exp fmp=1E ack=1", fmp, rot_ack);
    end
    tick();
    total++;
    if (fmp !== 8'h3C || rot_ack !== 1'b0) begin
      bad++;
      $display("FAIL b2b_e5 got fmp=%h ack=%b exp fmp=3C ack=0", fmp, rot_ack);
    end
    rot_req = 1'b0;
    tick();
    tick();
    total++;
    if (fmp !== 8'hF0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL b2b_e7 got fmp=%h wrap=%b exp fmp=F0 wrap=0", fmp, wrap);
    end
    rot_req = 1'b1; rot_dir = 1'b1;
    tick();
    total++;
    if (fmp !== 8'hC3 || wrap !== 1'b1 || rot_ack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_advwrap got fmp=%h wrap=%b ack=%b exp fmp=C3 wrap=1 ack=1", fmp, wrap, rot_ack);
    end
    rot_req = 1'b0;
    tick();
    total++;
    if (fmp !== 8'h87 || wrap !== 1'b0 || rot_ack !== 1'b0) begin
      bad++;
      $display("FAIL b2b_e9 got fmp=%h wrap=%b ack=%b exp fmp=87 wrap=0 ack=0", fmp, wrap, rot_ack);
    end
  endtask

  task automatic test_div0();
    logic [7:0] ef;
    logic       ew;
    start(8'd0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      ef = pat((n - 1) % 8);
      ew = ((n - 1) % 8) == 0;
      total++;
      if (fmp !== ef || wrap !== ew) begin
        bad++;
        $display("FAIL div0 n=%0d got fmp=%h wrap=%b exp fmp=%h wrap=%b", n, fmp, wrap, ef, ew);
      end
    end
  endtask

  task automatic test_hold_rst();
    start(8'd2);
    for (int n = 1; n <= 5; n++) tick();
    en = 1'b0; rot_req = 1'b1; rot_dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (fmp !== 8'hC3 || wrap !== 1'b0 || rot_ack !== 1'b0) begin
        bad++;
        $display("FAIL hold i=%0d got fmp=%h wrap=%b ack=%b exp fmp=C3 wrap=0 ack=0", i, fmp, wrap, rot_ack);
      end
    end
    en = 1'b1; rot_req = 1'b0;
    tick();
    total++;
    if (fmp !== 8'h87 || rot_ack !== 1'b0) begin
      bad++;
      $display("FAIL resume got fmp=%h ack=%b exp fmp=87 ack=0", fmp, rot_ack);
    end
    tick();
    tick();
    total++;
    if (fmp !== 8'h0F) begin
      bad++;
      $display("FAIL resume2 got=%h exp=0F", fmp);
    end
    rst = 1'b1; rot_req = 1'b1;
    tick();
    total++;
    if (fmp !== 8'h00 || rot_ack !== 1'b0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL midrst got fmp=%h ack=%b wrap=%b exp fmp=00 ack=0 wrap=0", fmp, rot_ack, wrap);
    end
    rst = 1'b0; en = 1'b0; rot_req = 1'b0;
    tick();
    tick();
    total++;
    if (fmp !== 8'h00) begin
      bad++;
      $display("FAIL idle_hold got=%h exp=00", fmp);
    end
    en = 1'b1; div_cfg = 8'd2;
    for (int n = 0; n <= 2; n++) tick();
    total++;
    if (fmp !== 8'hE1 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL restart got fmp=%h wrap=%b exp fmp=E1 wrap=1", fmp, wrap);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_div_change();
    test_rot_advance();
    test_rot_retard();
    test_back_to_back();
    test_div0();
    test_hold_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mphase_gen.md
MPHASE_GEN -- requirements
Module: mphase_gen

Interface
REQ-001 Parameter NPH, default 8: number of interleaved output phases; power of two, >= 4.
REQ-002 Parameter CW, default 8: width of the per-step divide configuration.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  run enable; low freezes all state.
REQ-006 div_cfg  input  CW  clk cycles per phase step; output period = NPH*div_q clk cycles.
REQ-007 rot_req  input  1  phase-rotation request, level, held until rot_ack.
REQ-008 rot_dir  input  1  1 = advance one step, 0 = retard one step; stable while rot_req high.
REQ-009 rot_ack  output  1  one-cycle pulse, rotation applied.
REQ-010 fmp  output  NPH  interleaved phase outputs, registered.
REQ-011 wrap  output  1  one-cycle pulse, step index crossed NPH-1 -> 0.

Function
REQ-012 The block SHALL have two states, IDLE and RUN.
REQ-013 In IDLE with en=1, the block SHALL enter RUN, load div_q = max(div_cfg,1), and clear tcnt to 0.
REQ-014 In IDLE, fmp SHALL be all zeros.
REQ-015 In RUN with en=1, tcnt SHALL increment each cycle; at tcnt==div_q-1 it SHALL return to 0 and a step SHALL occur.
REQ-016 At a step, sidx SHALL update to (sidx+inc) mod NPH.
REQ-017 inc SHALL be 1 normally, 2 for an accepted advance, and 0 for an accepted retard.
REQ-018 fmp[k] SHALL be 1 iff ((sidx_new - k) mod NPH) < NPH/2, registered on the step edge, so each bit has 50% duty.
REQ-019 Adjacent phases SHALL be offset by div_q cycles.
REQ-020 Between steps, fmp SHALL hold.
REQ-021 A rotation SHALL be accepted when rot_req=1 and rot_ack=0 at a step edge.
REQ-022 The accepted rotation SHALL be applied on that step.
REQ-023 rot_ack SHALL be high for the single cycle following that edge.
REQ-024 rot_req high while rot_ack=1 SHALL be ignored.
REQ-025 Only one rotation SHALL be applied per step.
REQ-026 wrap SHALL pulse for the cycle following a step where sidx+inc >= NPH.
REQ-027 A retard at sidx=NPH-1 SHALL produce no wrap.
REQ-028 An advance from NPH-1 to 1 SHALL produce a wrap.
REQ-029 div_q SHALL reload from max(div_cfg,1) only on a wrap step.
REQ-030 Changes to div_cfg SHALL not alter the current period.
REQ-031 div_cfg=0 SHALL behave as 1.
REQ-032 In RUN with en=0, tcnt, sidx, div_q and fmp SHALL hold.
REQ-033 In RUN with en=0, rot_ack and wrap SHALL be 0, and no rotation SHALL be accepted.
REQ-034 On en returning to 1, counting SHALL resume from the held tcnt.
REQ-035 The block SHALL not return to IDLE except by reset.
REQ-036 All arithmetic SHALL be unsigned.
REQ-037 sidx width SHALL be log2(NPH), wrapping naturally.
REQ-038 tcnt width SHALL be CW.

Reset
REQ-039 While rst=1 at an edge, the following SHALL be set: state=IDLE, tcnt=0, sidx=NPH-1, div_q=1, fmp=0, rot_ack=0, wrap=0.
REQ-040 rst SHALL take priority over en and rot_req.
REQ-041 rst asserted mid-RUN SHALL abort the current period and any pending rotation on the same edge.

Verification (NPH=8, CW=8)
REQ-042 Scenario: rst, then en=1, div_cfg=2 -> required response:
- RUN entered at edge E0;
- fmp=8'hE1 at E2, 8'hC3 at E4;
- fmp pattern repeats every 16 cycles;
- wrap pulses after each sidx 7->0.
REQ-043 Scenario: div_cfg changed 2->3 while sidx=3 -> required response:
- step spacing stays 2 until the next wrap;
- step spacing is 3 after the wrap;
- period becomes 24.
REQ-044 Scenario: rot_req=1, rot_dir=1 held at sidx=2 -> required response:
- next step gives sidx=4, fmp=8'h1E;
- rot_ack high exactly one cycle;
- a request re-held during ack is not double-applied.
REQ-045 Scenario: rot_req=1, rot_dir=0 at sidx=7 -> required response:
- sidx stays 7 for an extra div_q cycles;
- no wrap pulse on that step;
- rot_ack pulses once.
REQ-046 Scenario: div_cfg=0 -> required response:
- fmp changes every clock;
- period 8.
REQ-047 Scenario: en=0 for 5 cycles mid-step, then rst=1 mid-RUN -> required response:
- outputs hold during en=0;
- after the rst edge, fmp=0, state=IDLE, rot_ack=0, wrap=0.
